// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl_pkg
// Definitions shared by the nibble-serial adder controller and its slice:
//   - state_t   : controller state encoding (IDLE, RUN, DONE)
//   - NIBBLE_W  : width of the shared adder slice (4 bits)
//   - idx_w()   : width of the nibble index register for N nibble steps
// ---------------------------------------------------------------------------
package nibble_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // clog2(n), but never narrower than one bit so a single-nibble
    // configuration still has a legal index register.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// ---------------------------------------------------------------------------
// nibble_adder_slice
// Combinational 4-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a[3:0], b[3:0] : addends
//   cin            : carry in to bit 0
//   sum[3:0]       : sum bits
//   cout           : carry out of bit 3
// ---------------------------------------------------------------------------
module nibble_adder_slice
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
        logic w_p;
        assign w_p            = a[gi] ^ b[gi];
        assign sum[gi]        = w_p ^ w_carry[gi];
        assign w_carry[gi+1]  = (a[gi] & b[gi]) | (w_p & w_carry[gi]);
    end

    assign cout = w_carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Adds two WIDTH-bit operands through one shared 4-bit ripple-carry slice,
// one nibble per clock, LS nibble first, with a start/busy/done handshake.
// Optional macro: SERIAL_ADDER_SUB_EN -- when defined, sub=1 computes A-B
// (inverted B nibbles, initial carry 1); when undefined sub is ignored.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, accepted only in IDLE/DONE
//   sub   : 0 = add, 1 = subtract (sampled with start)
//   a, b  : WIDTH-bit operands, sampled on the accepting edge
//   busy  : high while nibbles are processed
//   done  : one-cycle pulse when sum/c_out are updated
//   sum   : result, held until next completion
//   c_out : carry out of bit WIDTH-1 (subtract: 1 = no borrow)
// WIDTH must be a multiple of 4 and at least 4.
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int N  = WIDTH / NIBBLE_W;
    localparam int IW = idx_w(N);

    state_t            r_state;
    state_t            w_state_next;
    logic [IW-1:0]     r_idx;
    logic              r_carry;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_res_sh;
    logic [WIDTH-1:0]  r_sum;
    logic              r_c_out;

    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_slice_sum;
    logic                w_slice_cout;
    logic                w_cin0;
    logic                w_last;
    logic [WIDTH-1:0]    w_res_next;

`ifdef SERIAL_ADDER_SUB_EN
    logic r_sub;

    // Subtract as A + ~B + 1: invert every B nibble, seed carry with 1.
    assign w_b_nib = r_b_sh[NIBBLE_W-1:0] ^ {NIBBLE_W{r_sub}};
    assign w_cin0  = sub;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub <= 1'b0;
        end else if (r_state != ST_RUN && start) begin
            r_sub <= sub;
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, r_res_sh[NIBBLE_W-1:0]};
`else
    assign w_b_nib = r_b_sh[NIBBLE_W-1:0];
    assign w_cin0  = 1'b0;

    logic w_unused;
    assign w_unused = &{1'b0, sub, r_res_sh[NIBBLE_W-1:0]};
`endif

    nibble_adder_slice u_slice (
        .a    (r_a_sh[NIBBLE_W-1:0]),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // Result register fills from the top, so after N steps the first
    // (least-significant) nibble has arrived at bit 0.
    if (N == 1) begin : g_res_single
        assign w_res_next = w_slice_sum;
    end else begin : g_res_multi
        assign w_res_next = {w_slice_sum, r_res_sh[WIDTH-1:NIBBLE_W]};
    end

    assign w_last = (r_idx == IW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand shift registers, carry, index and result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_sum    <= '0;
            r_c_out  <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_a_sh   <= r_a_sh >> NIBBLE_W;
            r_b_sh   <= r_b_sh >> NIBBLE_W;
            r_res_sh <= w_res_next;
            r_carry  <= w_slice_cout;
            r_idx    <= r_idx + IW'(1);
            // Outputs only move on the completion edge.
            if (w_last) begin
                r_sum   <= w_res_next;
                r_c_out <= w_slice_cout;
            end
        end else if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_idx   <= '0;
            r_carry <= w_cin0;
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;

endmodule
